// File: rtl/mem_resp_pkg.sv
// Shared state type, default geometry and built-in line image for the memory read responder.
// Pure declarations: no latency or backpressure of its own.
package mem_resp_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } resp_state_t;

   localparam int MEM_DATA_WIDTH = 64;
   localparam int MEM_DEPTH      = 16;
   localparam int MAX_LINE_WIDTH = 1024;

   // Every byte of line idx carries idx[7:0]; callers truncate to their line width.
   function automatic logic [MAX_LINE_WIDTH-1:0] pattern_line(input int unsigned idx);
      logic [7:0] b;
      b = idx[7:0];
      return {(MAX_LINE_WIDTH/8){b}};
   endfunction

endpackage

// File: rtl/mem_read_responder_resp_pipe.sv
// STAGES-deep valid+data delay line with synchronous clear; last stage holds data between strobes.
// Latency STAGES cycles, no backpressure; last_vld flags the entry that strobes on the next edge.
module resp_pipe #(
   parameter int DATA_WIDTH = 64,
   parameter int STAGES     = 2
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_dat,
   output logic                  last_vld,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_dat
);

   logic                  vld_d [1:STAGES];
   logic [DATA_WIDTH-1:0] dat_d [1:STAGES];
   logic                  vld_q [1:STAGES];
   logic [DATA_WIDTH-1:0] dat_q [1:STAGES];

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      if (k == 1) begin : g_first
         assign vld_d[k] = in_vld;
         assign dat_d[k] = in_dat;
      end else begin : g_rest
         assign vld_d[k] = vld_q[k-1];
         assign dat_d[k] = dat_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 1; k <= STAGES; k++) begin
         vld_q[k] <= clr ? 1'b0 : vld_d[k];
      end
   end

   // Only the output stage is cleared and held; inner data is don't-care without its valid.
   always_ff @(posedge clk) begin
      for (int k = 1; k < STAGES; k++) begin
         dat_q[k] <= dat_d[k];
      end
      if (clr) begin
         dat_q[STAGES] <= '0;
      end else if (vld_d[STAGES]) begin
         dat_q[STAGES] <= dat_d[STAGES];
      end
   end

   assign last_vld = vld_d[STAGES];
   assign out_vld  = vld_q[STAGES];
   assign out_dat  = dat_q[STAGES];

endmodule

// File: rtl/mem_read_responder.sv
// Read-only line memory behind a pipelined read port; accept to readdatavalid is LATENCY cycles.
// waitrequest is high during INIT_CYCLES after reset and while MAX_PENDING reads are unanswered.
module mem_read_responder
   import mem_resp_pkg::*;
#(
   parameter int    DATA_WIDTH  = MEM_DATA_WIDTH,
   parameter int    DEPTH       = MEM_DEPTH,
   parameter int    LATENCY     = 2,
   parameter int    MAX_PENDING = 2,
   parameter int    INIT_CYCLES = 4,
   parameter string INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           address,
   input  logic                  read,
   output logic                  waitrequest,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  readdatavalid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

   resp_state_t           state_q, state_d;
   logic [CW-1:0]         init_cnt_q, init_cnt_d;
   logic [PW-1:0]         pending_q;
   logic                  accept;
   logic                  retire;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] lines [DEPTH];
   logic [DATA_WIDTH-1:0] line_q;
   logic                  oob_q;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_dat;

   // Line image is loaded once and never written, so reset leaves contents untouched.
   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         lines[i] = DATA_WIDTH'(pattern_line(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      waitrequest = 1'b1;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d = ST_READY;
            end else begin
               init_cnt_d = init_cnt_q + CW'(1);
            end
         end
         ST_READY: begin
            // A retiring response frees its slot in time for a same-cycle accept.
            waitrequest = (pending_q == PW'(MAX_PENDING)) && !retire;
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign accept   = read && !waitrequest;
   assign in_range = (address < 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else if (accept && !retire) begin
         pending_q <= pending_q + PW'(1);
      end else if (!accept && retire) begin
         pending_q <= pending_q - PW'(1);
      end
   end

   // Synchronous-read port; this register is the first cycle of LATENCY.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_q <= lines[address[AW-1:0]];
         oob_q  <= !in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= accept;
      end
   end

   assign rd_dat = oob_q ? '0 : line_q;

   resp_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (LATENCY)
   ) u_resp_pipe (
      .clk      (clk),
      .clr      (rst),
      .in_vld   (rd_vld_q),
      .in_dat   (rd_dat),
      .last_vld (retire),
      .out_vld  (readdatavalid),
      .out_dat  (readdata)
   );

endmodule

// File: tb/tb_mem_read_responder.sv
// Drives two responders (MAX_PENDING 2 and 1) with shared stimulus and compares each cycle
// against a time-stamped response queue derived from the accept/latency/pending rules.
module tb_mem_read_responder;

   localparam int LAT      = 2;
   localparam int INIT_CYC = 4;
   localparam int DEPTH    = 16;

   typedef struct {
      int          due;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic [31:0] address;
   logic [1:0]  waitrequest;
   logic [1:0]  readdatavalid;
   logic [63:0] readdata [2];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [63:0] line_of(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return (a < 32'(DEPTH)) ? {8{b}} : 64'h0;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int MAXP = (g == 0) ? 2 : 1;

      exp_t        q[$];
      exp_t        cur;
      logic [63:0] last_data;
      int          last_rst;
      bit          have_reset = 1'b0;
      bit          ev;
      bit          ret;
      bit          ready;
      bit          exp_wr;

      mem_read_responder #(
         .DATA_WIDTH  (64),
         .DEPTH       (DEPTH),
         .LATENCY     (LAT),
         .MAX_PENDING (MAXP),
         .INIT_CYCLES (INIT_CYC),
         .INIT_FILE   ("")
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .address       (address),
         .read          (read),
         .waitrequest   (waitrequest[g]),
         .readdata      (readdata[g]),
         .readdatavalid (readdatavalid[g])
      );

      // Cycle between edge cyc and cyc+1: decide what must be visible now and what the next edge accepts.
      always @(negedge clk) begin
         ev     = 1'b0;
         exp_wr = 1'b1;
         if (have_reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
               ev  = 1'b1;
               cur = q.pop_front();
            end
            check($sformatf("vld%0d", g), readdatavalid[g], ev);
            if (ev) begin
               check($sformatf("data%0d", g), readdata[g], cur.data);
               last_data = cur.data;
            end else begin
               check($sformatf("hold%0d", g), readdata[g], last_data);
            end
            ready  = (cyc - last_rst) >= INIT_CYC;
            ret    = (q.size() > 0) && (q[0].due == cyc + 1);
            exp_wr = !ready || ((q.size() == MAXP) && !ret);
            check($sformatf("wait%0d", g), waitrequest[g], exp_wr);
         end
         if (rst) begin
            q.delete();
            last_rst   = cyc + 1;
            last_data  = 64'h0;
            have_reset = 1'b1;
         end else if (have_reset && read && !exp_wr) begin
            q.push_back('{due: cyc + 1 + LAT, data: line_of(address)});
         end
      end
   end

   task automatic drive(input logic r, input logic [31:0] a);
      read    = r;
      address = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned pick;
      rst     = 1'b1;
      read    = 1'b1;
      address = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Read held at line 0 through the init window.
      repeat (10) drive(1'b1, 32'd0);
      repeat (3) drive(1'b0, 32'd0);

      drive(1'b1, 32'd1);
      drive(1'b1, 32'd2);
      drive(1'b1, 32'd3);
      repeat (4) drive(1'b0, 32'd0);

      drive(1'b1, 32'd16);
      drive(1'b1, 32'hFFFF_FFFF);
      repeat (4) drive(1'b0, 32'd0);

      drive(1'b1, 32'd5);
      repeat (5) drive(1'b0, 32'd7);

      // Two reads in flight, then reset before their strobes.
      drive(1'b1, 32'd9);
      drive(1'b1, 32'd10);
      rst = 1'b1;
      drive(1'b0, 32'd0);
      rst = 1'b0;
      repeat (8) drive(1'b0, 32'd0);

      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         pick = $urandom_range(0, 19);
         drive($urandom_range(0, 9) < 7, (pick == 19) ? $urandom : pick);
      end
      rst = 1'b0;
      repeat (6) drive(1'b0, 32'd0);

      repeat (14) drive(1'b1, 32'd4);
      repeat (6) drive(1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
